controller_seq: RTL and testbench



---
 rtl/controller_seq.sv | 92 +++++++++
 tb/tb_controller_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/controller_seq.sv
// controller_seq: microcoded sequencer turning opcode/flags/step into a 16-bit control word
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   opcode     instruction opcode field (bits above 3 nonzero decode as NOP)
//   flag_c     carry flag, consulted by JC at step 3
//   flag_z     zero flag, consulted by JZ at step 3
//   step_en    advance enable; low holds the step counter
//   out        control word {HLT,PC_INC,PC_EN,PC_LOAD,MAR_LOAD,MEM_EN,MEM_LOAD,IR_LOAD,
//              IR_EN,A_LOAD,A_EN,B_LOAD,ADDER_SUB,ADDER_EN,OUT_LOAD,FLAGS_LOAD}
//   stage      current step counter
//   halted     sticky halt status
//   instr_done high during the final step of the current instruction
module controller_seq #(
    parameter int unsigned OPCODE_W  = 4,
    parameter bit          EARLY_END = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    input  logic                step_en,
    output logic [15:0]         out,
    output logic [2:0]          stage,
    output logic                halted,
    output logic                instr_done
);
    logic [2:0]  stage_q, stage_d;
    logic        halted_q, halted_d;
    logic [3:0]  op;
    logic [2:0]  last;
    logic [15:0] exec, ctrl;
    logic        s3, s4, s5, is_hlt;
    always_comb begin
        // Any set bit above the 4-bit opcode field forces the undefined code 1000 (NOP).
        op = ((opcode >> 4) != '0) ? 4'h8 : opcode[3:0];
        s3 = stage_q == 3'd3;
        s4 = stage_q == 3'd4;
        s5 = stage_q == 3'd5;
        last = 3'd3;
        exec = '0;
        case (op)
            4'h0: begin
                last = 3'd4;
                exec = s3 ? 16'h0880 : s4 ? 16'h0440 : '0;
            end
            4'h1, 4'h2: begin
                last = 3'd5;
                exec = s3 ? 16'h0880 : s4 ? 16'h0410 : s5 ? (op[1] ? 16'h004D : 16'h0045) : '0;
            end
            4'h3: begin
                last = 3'd4;
                exec = s3 ? 16'h0880 : s4 ? 16'h0220 : '0;
            end
            4'h4: exec = s3 ? 16'h00C0 : '0;
            4'h5: exec = s3 ? 16'h1080 : '0;
            4'h6: exec = (s3 && flag_c) ? 16'h1080 : '0;
            4'h7: exec = (s3 && flag_z) ? 16'h1080 : '0;
            4'hE: exec = s3 ? 16'h0022 : '0;
            // HLT has no terminating step; 7 never matches a reachable stage.
            4'hF: begin
                last = 3'd7;
                exec = s3 ? 16'h8000 : '0;
            end
            default: exec = '0;
        endcase
        ctrl = (stage_q == 3'd0) ? 16'h2800 : (stage_q == 3'd1) ? 16'h4000 :
               (stage_q == 3'd2) ? 16'h0500 : exec;
        is_hlt = s3 && op == 4'hF;
        out = halted_q ? 16'h8000 : ctrl;
        instr_done = !halted_q && (EARLY_END ? stage_q == last : s5);
        stage = stage_q;
        halted = halted_q;
        stage_d = stage_q;
        halted_d = halted_q;
        if (step_en && !halted_q) begin
            // Entering halt keeps the counter parked at step 3.
            if (is_hlt) halted_d = 1'b1;
            else stage_d = (instr_done || s5) ? 3'd0 : stage_q + 3'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            halted_q <= halted_d;
        end
    end
endmodule

// File: tb/tb_controller_seq.sv
// tb_controller_seq: directed scoreboard bench for controller_seq (EARLY_END=1 and EARLY_END=0 instances)
module tb_controller_seq;
    typedef struct packed {
        logic [15:0] out;
        logic [2:0]  stage;
        logic        halted;
        logic        done;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  opcode = 4'h4;
    logic        flag_c = 1'b0;
    logic        flag_z = 1'b0;
    logic        step_en = 1'b1;
    logic [15:0] out_a, out_b;
    logic [2:0]  stage_a, stage_b;
    logic        halted_a, halted_b, done_a, done_b;
    bit          sel_b = 1'b0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    string       tq[$];
    always #5 clk = ~clk;
    controller_seq #(.OPCODE_W(4), .EARLY_END(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .step_en(step_en), .out(out_a), .stage(stage_a), .halted(halted_a), .instr_done(done_a)
    );
    controller_seq #(.OPCODE_W(4), .EARLY_END(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .step_en(step_en), .out(out_b), .stage(stage_b), .halted(halted_b), .instr_done(done_b)
    );
    task automatic chk();
        exp_t  e, o;
        string t;
        e = sb.pop_front();
        t = tq.pop_front();
        o = sel_b ? {out_b, stage_b, halted_b, done_b} : {out_a, stage_a, halted_a, done_a};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got out=%h stage=%0d halted=%b done=%b, want out=%h stage=%0d halted=%b done=%b",
                   t, o.out, o.stage, o.halted, o.done, e.out, e.stage, e.halted, e.done);
        end
    endtask
    task automatic tick(input string t, input logic [15:0] eo, input logic [2:0] es,
                        input logic eh, input logic ed);
        sb.push_back('{eo, es, eh, ed});
        tq.push_back(t);
        @(posedge clk);
        @(negedge clk);
        chk();
    endtask
    task automatic now(input string t, input logic [15:0] eo, input logic [2:0] es,
                       input logic eh, input logic ed);
        sb.push_back('{eo, es, eh, ed});
        tq.push_back(t);
        #2;
        chk();
    endtask
    task automatic fetch(input string t);
        tick({t, "_s1"}, 16'h4000, 3'd1, 1'b0, 1'b0);
        tick({t, "_s2"}, 16'h0500, 3'd2, 1'b0, 1'b0);
    endtask
    initial begin
        @(negedge clk);
        @(negedge clk);
        now("rst", 16'h2800, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        now("rst_rel", 16'h2800, 3'd0, 1'b0, 1'b0);
        fetch("ldi");
        tick("ldi_s3", 16'h00C0, 3'd3, 1'b0, 1'b1);
        tick("ldi_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        opcode = 4'h1;
        fetch("add");
        tick("add_s3", 16'h0880, 3'd3, 1'b0, 1'b0);
        tick("add_s4", 16'h0410, 3'd4, 1'b0, 1'b0);
        tick("add_s5", 16'h0045, 3'd5, 1'b0, 1'b1);
        tick("add_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        opcode = 4'h2;
        fetch("sub");
        tick("sub_s3", 16'h0880, 3'd3, 1'b0, 1'b0);
        tick("sub_s4", 16'h0410, 3'd4, 1'b0, 1'b0);
        tick("sub_s5", 16'h004D, 3'd5, 1'b0, 1'b1);
        tick("sub_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        opcode = 4'h0;
        fetch("lda");
        tick("lda_s3", 16'h0880, 3'd3, 1'b0, 1'b0);
        tick("lda_s4", 16'h0440, 3'd4, 1'b0, 1'b1);
        tick("lda_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        opcode = 4'h3;
        fetch("sta");
        tick("sta_s3", 16'h0880, 3'd3, 1'b0, 1'b0);
        tick("sta_s4", 16'h0220, 3'd4, 1'b0, 1'b1);
        tick("sta_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        opcode = 4'h6;
        flag_c = 1'b1;
        fetch("jc1");
        tick("jc1_s3", 16'h1080, 3'd3, 1'b0, 1'b1);
        tick("jc1_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        flag_c = 1'b0;
        fetch("jc0");
        tick("jc0_s3", 16'h0000, 3'd3, 1'b0, 1'b1);
        tick("jc0_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        opcode = 4'h7;
        flag_z = 1'b1;
        fetch("jz1");
        tick("jz1_s3", 16'h1080, 3'd3, 1'b0, 1'b1);
        tick("jz1_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        flag_z = 1'b0;
        opcode = 4'hE;
        fetch("out");
        tick("out_s3", 16'h0022, 3'd3, 1'b0, 1'b1);
        tick("out_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        opcode = 4'h8;
        tick("hold_s1", 16'h4000, 3'd1, 1'b0, 1'b0);
        step_en = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold", 16'h4000, 3'd1, 1'b0, 1'b0);
        step_en = 1'b1;
        tick("resume_s2", 16'h0500, 3'd2, 1'b0, 1'b0);
        tick("nop_s3", 16'h0000, 3'd3, 1'b0, 1'b1);
        tick("nop_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        opcode = 4'hF;
        fetch("hlt");
        tick("hlt_s3", 16'h8000, 3'd3, 1'b0, 1'b0);
        tick("hlt_set", 16'h8000, 3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step_en = i[0];
            tick("halted", 16'h8000, 3'd3, 1'b1, 1'b0);
        end
        step_en = 1'b1;
        rst_n = 1'b0;
        now("hlt_rst", 16'h2800, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        opcode = 4'h4;
        fetch("mid");
        rst_n = 1'b0;
        now("mid_rst", 16'h2800, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        opcode = 4'h0;
        sel_b = 1'b1;
        now("b_rst", 16'h2800, 3'd0, 1'b0, 1'b0);
        fetch("b_lda");
        tick("b_lda_s3", 16'h0880, 3'd3, 1'b0, 1'b0);
        tick("b_lda_s4", 16'h0440, 3'd4, 1'b0, 1'b0);
        tick("b_lda_s5", 16'h0000, 3'd5, 1'b0, 1'b1);
        tick("b_lda_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        opcode = 4'h4;
        fetch("b_ldi");
        tick("b_ldi_s3", 16'h00C0, 3'd3, 1'b0, 1'b0);
        tick("b_ldi_s4", 16'h0000, 3'd4, 1'b0, 1'b0);
        tick("b_ldi_s5", 16'h0000, 3'd5, 1'b0, 1'b1);
        tick("b_ldi_s0", 16'h2800, 3'd0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
